// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch button front-end: classifier states and press-type codes.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        LONG,
        DB_REL
    } state_t;

    localparam logic [1:0] PT_NONE  = 2'b00;
    localparam logic [1:0] PT_SHORT = 2'b01;
    localparam logic [1:0] PT_LONG  = 2'b10;

    function automatic logic [31:0] max_u32(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for the raw pushbutton level, synchronous active-high reset.
module btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_press_classifier.sv
// Debounces a synchronised pushbutton and classifies presses as short (+1) or long (+10).
// Auto-repeat of long strobes while held is built only when BTN_AUTOREPEAT_EN is defined.
//
// state    | meaning
// IDLE     | button released and stable
// DB_PRESS | press seen, counting stable samples before accepting it
// HELD     | accepted press, counting hold time towards long
// LONG     | long strobe already issued; optional periodic repeats
// DB_REL   | release seen, debouncing it; ret remembers HELD or LONG
module button_press_classifier
    import stopwatch_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [31:0] LONG_CYCLES     = 32'd50000000,
    parameter logic [31:0] REPEAT_CYCLES   = 32'd12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       press_valid,
    output logic [1:0] press_type,
    output logic       btn_level
);

    localparam logic [31:0] MAX_CYC =
        max_u32(max_u32({16'd0, DEBOUNCE_CYCLES}, LONG_CYCLES), REPEAT_CYCLES);
    localparam int CW = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] DB_TC   = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CW-1:0] RPT_TC  = CW'(REPEAT_CYCLES);
`endif

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    logic s;

    btn_sync u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (s)
    );

    state_t          state_q, state_d;
    state_t          ret_q, ret_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   hold_q, hold_d;
`ifdef BTN_AUTOREPEAT_EN
    logic [CW-1:0]   rpt_q, rpt_d;
`endif
    logic            press_valid_q, press_valid_d;
    logic [1:0]      press_type_q, press_type_d;
    logic            btn_level_q, btn_level_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ret_q         <= HELD;
            cnt_q         <= '0;
            hold_q        <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q         <= '0;
`endif
            press_valid_q <= 1'b0;
            press_type_q  <= PT_NONE;
            btn_level_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q         <= rpt_d;
`endif
            press_valid_q <= press_valid_d;
            press_type_q  <= press_type_d;
            btn_level_q   <= btn_level_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        cnt_d         = cnt_q;
        hold_d        = hold_q;
`ifdef BTN_AUTOREPEAT_EN
        rpt_d         = rpt_q;
`endif
        press_valid_d = 1'b0;
        press_type_d  = PT_NONE;
        btn_level_d   = btn_level_q;

        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = DB_PRESS;
                    cnt_d   = CW'(1);
                end
            end

            DB_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_d == DB_TC) begin
                        state_d     = HELD;
                        btn_level_d = 1'b1;
                        hold_d      = '0;
                    end
                end
            end

            HELD: begin
                // Hold keeps counting on the cycle s drops; a long decision beats the release.
                hold_d = sat_inc(hold_q);
                if (hold_d == LONG_TC) begin
                    state_d       = LONG;
                    press_valid_d = 1'b1;
                    press_type_d  = PT_LONG;
`ifdef BTN_AUTOREPEAT_EN
                    rpt_d         = '0;
`endif
                end else if (!s) begin
                    state_d = DB_REL;
                    cnt_d   = CW'(1);
                    ret_d   = HELD;
                end
            end

            LONG: begin
`ifdef BTN_AUTOREPEAT_EN
                rpt_d = sat_inc(rpt_q);
                if (rpt_d == RPT_TC) begin
                    press_valid_d = 1'b1;
                    press_type_d  = PT_LONG;
                    rpt_d         = '0;
                end
`endif
                if (!s) begin
                    state_d = DB_REL;
                    cnt_d   = CW'(1);
                    ret_d   = LONG;
                end
            end

            DB_REL: begin
                if (s) begin
                    state_d = ret_q;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_d == DB_TC) begin
                        state_d     = IDLE;
                        btn_level_d = 1'b0;
                        if (ret_q == HELD) begin
                            press_valid_d = 1'b1;
                            press_type_d  = PT_SHORT;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign press_valid = press_valid_q;
    assign press_type  = press_type_q;
    assign btn_level   = btn_level_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with DEBOUNCE=4, LONG=20, REPEAT=8.
module tb_button_press_classifier;
    import stopwatch_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_raw;
    logic       press_valid;
    logic [1:0] press_type;
    logic       btn_level;

    always #5 clk = ~clk;

    button_press_classifier #(
        .DEBOUNCE_CYCLES (16'd4),
        .LONG_CYCLES     (32'd20),
        .REPEAT_CYCLES   (32'd8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .press_valid (press_valid),
        .press_type  (press_type),
        .btn_level   (btn_level)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int bad_type = 0;
    int r;

    int         ev_cyc[$];
    logic [1:0] ev_type[$];
    int         exp_c[$];
    logic [1:0] exp_t[$];
    logic       lvl_hist[0:4095];
    logic       pv_hist[0:4095];

    // Advance n clock edges, sampling 1 time unit after each edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            lvl_hist[cyc] = btn_level;
            pv_hist[cyc]  = press_valid;
            if (press_valid) begin
                ev_cyc.push_back(cyc);
                ev_type.push_back(press_type);
            end else if (press_type != PT_NONE) begin
                bad_type++;
            end
        end
    endtask

    task automatic start_test();
        ev_cyc.delete();
        ev_type.delete();
        exp_c.delete();
        exp_t.delete();
        r = cyc;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        btn_raw = 1'b0;
        run(3);
        n_checks++;
        if (press_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", press_valid); end
        n_checks++;
        if (press_type !== PT_NONE) begin n_fail++; $display("FAIL reset_type: got %b want 00", press_type); end
        n_checks++;
        if (btn_level !== 1'b0) begin n_fail++; $display("FAIL reset_level: got %b want 0", btn_level); end
        reset = 1'b0;
        run(5);
    endtask

    task automatic test_clean_press();
        start_test();
        btn_raw = 1'b1; run(16);
        btn_raw = 1'b0; run(24);
        exp_c.push_back(22); exp_t.push_back(PT_SHORT);
        n_checks++;
        if (ev_cyc.size() !== exp_c.size()) begin n_fail++; $display("FAIL clean_count: got %0d want %0d", ev_cyc.size(), exp_c.size()); end
        for (int i = 0; i < exp_c.size() && i < ev_cyc.size(); i++) begin
            n_checks++;
            if ((ev_cyc[i] - r) !== exp_c[i]) begin n_fail++; $display("FAIL clean_cycle[%0d]: got %0d want %0d", i, ev_cyc[i] - r, exp_c[i]); end
            n_checks++;
            if (ev_type[i] !== exp_t[i]) begin n_fail++; $display("FAIL clean_type[%0d]: got %b want %b", i, ev_type[i], exp_t[i]); end
        end
        n_checks++;
        if (lvl_hist[r+5] !== 1'b0) begin n_fail++; $display("FAIL clean_level_pre: got %b want 0", lvl_hist[r+5]); end
        n_checks++;
        if (lvl_hist[r+6] !== 1'b1) begin n_fail++; $display("FAIL clean_level_rise: got %b want 1", lvl_hist[r+6]); end
        n_checks++;
        if (lvl_hist[r+21] !== 1'b1) begin n_fail++; $display("FAIL clean_level_hold: got %b want 1", lvl_hist[r+21]); end
        n_checks++;
        if (lvl_hist[r+22] !== 1'b0) begin n_fail++; $display("FAIL clean_level_fall: got %b want 0", lvl_hist[r+22]); end
    endtask

    task automatic test_bounce();
        logic any_level;
        start_test();
        btn_raw = 1'b1; run(2);
        btn_raw = 1'b0; run(2);
        btn_raw = 1'b1; run(2);
        btn_raw = 1'b0; run(6);
        btn_raw = 1'b1; run(3);
        btn_raw = 1'b0; run(12);
        any_level = 1'b0;
        for (int c = r + 1; c <= cyc; c++) any_level = any_level | lvl_hist[c];
        n_checks++;
        if (ev_cyc.size() !== 0) begin n_fail++; $display("FAIL bounce_count: got %0d want 0", ev_cyc.size()); end
        n_checks++;
        if (any_level !== 1'b0) begin n_fail++; $display("FAIL bounce_level: got %b want 0", any_level); end
    endtask

    task automatic test_min_press();
        start_test();
        btn_raw = 1'b1; run(4);
        btn_raw = 1'b0; run(16);
        n_checks++;
        if (ev_cyc.size() !== 1) begin n_fail++; $display("FAIL minpress_count: got %0d want 1", ev_cyc.size()); end
        if (ev_cyc.size() > 0) begin
            n_checks++;
            if ((ev_cyc[0] - r) !== 10) begin n_fail++; $display("FAIL minpress_cycle: got %0d want 10", ev_cyc[0] - r); end
            n_checks++;
            if (ev_type[0] !== PT_SHORT) begin n_fail++; $display("FAIL minpress_type: got %b want 01", ev_type[0]); end
        end
        n_checks++;
        if (lvl_hist[r+6] !== 1'b1) begin n_fail++; $display("FAIL minpress_level: got %b want 1", lvl_hist[r+6]); end
    endtask

    task automatic test_long_hold();
        start_test();
        btn_raw = 1'b1; run(40);
        btn_raw = 1'b0; run(30);
        exp_c.push_back(26); exp_t.push_back(PT_LONG);
`ifdef BTN_AUTOREPEAT_EN
        exp_c.push_back(34); exp_t.push_back(PT_LONG);
        exp_c.push_back(42); exp_t.push_back(PT_LONG);
`endif
        n_checks++;
        if (ev_cyc.size() !== exp_c.size()) begin n_fail++; $display("FAIL long_count: got %0d want %0d", ev_cyc.size(), exp_c.size()); end
        for (int i = 0; i < exp_c.size() && i < ev_cyc.size(); i++) begin
            n_checks++;
            if ((ev_cyc[i] - r) !== exp_c[i]) begin n_fail++; $display("FAIL long_cycle[%0d]: got %0d want %0d", i, ev_cyc[i] - r, exp_c[i]); end
            n_checks++;
            if (ev_type[i] !== exp_t[i]) begin n_fail++; $display("FAIL long_type[%0d]: got %b want %b", i, ev_type[i], exp_t[i]); end
        end
        n_checks++;
        if (lvl_hist[r+45] !== 1'b1) begin n_fail++; $display("FAIL long_level_hold: got %b want 1", lvl_hist[r+45]); end
        n_checks++;
        if (lvl_hist[r+46] !== 1'b0) begin n_fail++; $display("FAIL long_level_fall: got %b want 0", lvl_hist[r+46]); end
    endtask

    task automatic test_glitch();
        start_test();
        btn_raw = 1'b1; run(10);
        btn_raw = 1'b0; run(2);
        btn_raw = 1'b1; run(28);
        btn_raw = 1'b0; run(30);
        exp_c.push_back(28); exp_t.push_back(PT_LONG);
`ifdef BTN_AUTOREPEAT_EN
        exp_c.push_back(36); exp_t.push_back(PT_LONG);
`endif
        n_checks++;
        if (ev_cyc.size() !== exp_c.size()) begin n_fail++; $display("FAIL glitch_count: got %0d want %0d", ev_cyc.size(), exp_c.size()); end
        for (int i = 0; i < exp_c.size() && i < ev_cyc.size(); i++) begin
            n_checks++;
            if ((ev_cyc[i] - r) !== exp_c[i]) begin n_fail++; $display("FAIL glitch_cycle[%0d]: got %0d want %0d", i, ev_cyc[i] - r, exp_c[i]); end
            n_checks++;
            if (ev_type[i] !== exp_t[i]) begin n_fail++; $display("FAIL glitch_type[%0d]: got %b want %b", i, ev_type[i], exp_t[i]); end
        end
        n_checks++;
        if (lvl_hist[r+14] !== 1'b1) begin n_fail++; $display("FAIL glitch_level: got %b want 1", lvl_hist[r+14]); end
        n_checks++;
        if (lvl_hist[r+46] !== 1'b0) begin n_fail++; $display("FAIL glitch_level_fall: got %b want 0", lvl_hist[r+46]); end
    endtask

    task automatic test_long_coincide();
        start_test();
        btn_raw = 1'b1; run(23);
        btn_raw = 1'b0; run(20);
        n_checks++;
        if (ev_cyc.size() !== 1) begin n_fail++; $display("FAIL coincide_count: got %0d want 1", ev_cyc.size()); end
        if (ev_cyc.size() > 0) begin
            n_checks++;
            if ((ev_cyc[0] - r) !== 26) begin n_fail++; $display("FAIL coincide_cycle: got %0d want 26", ev_cyc[0] - r); end
            n_checks++;
            if (ev_type[0] !== PT_LONG) begin n_fail++; $display("FAIL coincide_type: got %b want 10", ev_type[0]); end
        end
        n_checks++;
        if (lvl_hist[r+29] !== 1'b1) begin n_fail++; $display("FAIL coincide_level_hold: got %b want 1", lvl_hist[r+29]); end
        n_checks++;
        if (lvl_hist[r+30] !== 1'b0) begin n_fail++; $display("FAIL coincide_level_fall: got %b want 0", lvl_hist[r+30]); end
    endtask

    task automatic test_near_long();
        start_test();
        btn_raw = 1'b1; run(22);
        btn_raw = 1'b0; run(20);
        n_checks++;
        if (ev_cyc.size() !== 1) begin n_fail++; $display("FAIL nearlong_count: got %0d want 1", ev_cyc.size()); end
        if (ev_cyc.size() > 0) begin
            n_checks++;
            if ((ev_cyc[0] - r) !== 28) begin n_fail++; $display("FAIL nearlong_cycle: got %0d want 28", ev_cyc[0] - r); end
            n_checks++;
            if (ev_type[0] !== PT_SHORT) begin n_fail++; $display("FAIL nearlong_type: got %b want 01", ev_type[0]); end
        end
    endtask

    task automatic test_reset_mid_press();
        start_test();
        btn_raw = 1'b1; run(10);
        reset   = 1'b1; run(2);
        reset   = 1'b0; run(12);
        btn_raw = 1'b0; run(14);
        n_checks++;
        if (lvl_hist[r+10] !== 1'b1) begin n_fail++; $display("FAIL rst_level_before: got %b want 1", lvl_hist[r+10]); end
        n_checks++;
        if (lvl_hist[r+11] !== 1'b0) begin n_fail++; $display("FAIL rst_level_cleared: got %b want 0", lvl_hist[r+11]); end
        n_checks++;
        if (pv_hist[r+12] !== 1'b0) begin n_fail++; $display("FAIL rst_valid_cleared: got %b want 0", pv_hist[r+12]); end
        n_checks++;
        if (lvl_hist[r+17] !== 1'b0) begin n_fail++; $display("FAIL rst_redebounce_pre: got %b want 0", lvl_hist[r+17]); end
        n_checks++;
        if (lvl_hist[r+18] !== 1'b1) begin n_fail++; $display("FAIL rst_redebounce_rise: got %b want 1", lvl_hist[r+18]); end
        n_checks++;
        if (ev_cyc.size() !== 1) begin n_fail++; $display("FAIL rst_count: got %0d want 1", ev_cyc.size()); end
        if (ev_cyc.size() > 0) begin
            n_checks++;
            if ((ev_cyc[0] - r) !== 30) begin n_fail++; $display("FAIL rst_cycle: got %0d want 30", ev_cyc[0] - r); end
            n_checks++;
            if (ev_type[0] !== PT_SHORT) begin n_fail++; $display("FAIL rst_type: got %b want 01", ev_type[0]); end
        end
    endtask

    task automatic test_type_idle();
        n_checks++;
        if (bad_type !== 0) begin n_fail++; $display("FAIL type_when_idle: got %0d cycles want 0", bad_type); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_min_press();
        test_long_hold();
        test_glitch();
        test_long_coincide();
        test_near_long();
        test_reset_mid_press();
        test_type_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
